// File: rtl/tweezer_pi_sequencer.sv
// Control-plane sequencer for the tweezer PI loop: host command decode, bumpless
// arm (reset-held settle window) and slew-limited setpoint ramp while running.
module tweezer_pi_sequencer #(
  parameter int unsigned inputBitSize  = 16,
  parameter int unsigned coeffBitSize  = 10,
  parameter int unsigned rateBitSize   = 16,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [coeffBitSize-1:0] cmd_kp,
  input  logic [coeffBitSize-1:0] cmd_ki,
  input  logic [inputBitSize-1:0] cmd_setpoint,
  input  logic [inputBitSize-1:0] ramp_step,
  input  logic [rateBitSize-1:0]  ramp_period,
  input  logic                    hold_req,
  output logic                    PI_reset,
  output logic                    PI_enable,
  output logic                    PI_freeze,
  output logic [coeffBitSize-1:0] PI_kp,
  output logic [coeffBitSize-1:0] PI_ki,
  output logic                    PI_kp_update,
  output logic                    PI_ki_update,
  output logic [inputBitSize-1:0] PI_setpoint,
  output logic                    at_target,
  output logic [1:0]              state
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned DW = inputBitSize + 1;

  localparam logic [1:0] OP_START      = 2'd0;
  localparam logic [1:0] OP_STOP       = 2'd1;
  localparam logic [1:0] OP_SET_GAINS  = 2'd2;
  localparam logic [1:0] OP_SET_TARGET = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                  state_q, state_n;
  logic [SW-1:0]           settle_q, settle_n;
  logic [rateBitSize-1:0]  tick_q, tick_n;
  logic [inputBitSize-1:0] target_q, target_n;
  logic [inputBitSize-1:0] sp_n;
  logic [coeffBitSize-1:0] kp_n, ki_n;
  logic                    upd_n;
  logic [DW-1:0]           diff, mag;
  logic                    accept;

  assign state     = state_q;
  assign cmd_ready = !reset && (state_q == S_IDLE || state_q == S_RUN);
  assign accept    = cmd_valid && cmd_ready;

  // Sign-extended difference cannot overflow, so its magnitude is exact
  assign diff = {target_q[inputBitSize-1], target_q} - {PI_setpoint[inputBitSize-1], PI_setpoint};
  assign mag  = diff[DW-1] ? (~diff + DW'(1)) : diff;

  always_comb begin
    state_n  = state_q;
    settle_n = settle_q;
    tick_n   = '0;
    target_n = target_q;
    sp_n     = PI_setpoint;
    kp_n     = PI_kp;
    ki_n     = PI_ki;
    upd_n    = 1'b0;

    // Ramp stepping uses the target held before any same-edge SET_TARGET
    if (state_q == S_RUN) begin
      tick_n = tick_q;
      if (!hold_req) begin
        if (tick_q == ramp_period) begin
          tick_n = '0;
          if (diff != '0) begin
            if (ramp_step == '0 || mag <= DW'(ramp_step)) sp_n = target_q;
            else if (diff[DW-1])                            sp_n = PI_setpoint - ramp_step;
            else                                            sp_n = PI_setpoint + ramp_step;
          end
        end else begin
          tick_n = tick_q + rateBitSize'(1);
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        settle_n = '0;
        if (accept && cmd_op == OP_START) state_n = S_ARM;
      end
      S_ARM: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          settle_n = '0;
          state_n  = S_RUN;
        end else begin
          settle_n = settle_q + SW'(1);
        end
      end
      S_RUN: begin
        if (accept && cmd_op == OP_STOP) state_n = S_DRAIN;
      end
      default: state_n = S_IDLE;
    endcase

    if (accept && cmd_op == OP_SET_GAINS) begin
      kp_n  = cmd_kp;
      ki_n  = cmd_ki;
      upd_n = 1'b1;
    end
    if (accept && cmd_op == OP_SET_TARGET) begin
      target_n = cmd_setpoint;
      if (state_q == S_IDLE) sp_n = cmd_setpoint;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      settle_q     <= '0;
      tick_q       <= '0;
      target_q     <= '0;
      PI_setpoint  <= '0;
      PI_kp        <= '0;
      PI_ki        <= '0;
      PI_kp_update <= 1'b0;
      PI_ki_update <= 1'b0;
      PI_reset     <= 1'b0;
      PI_enable    <= 1'b0;
      PI_freeze    <= 1'b0;
      at_target    <= 1'b1;
    end else begin
      state_q      <= state_n;
      settle_q     <= settle_n;
      tick_q       <= tick_n;
      target_q     <= target_n;
      PI_setpoint  <= sp_n;
      PI_kp        <= kp_n;
      PI_ki        <= ki_n;
      PI_kp_update <= upd_n;
      PI_ki_update <= upd_n;
      PI_reset     <= (state_n == S_ARM) || (state_n == S_DRAIN);
      PI_enable    <= (state_n == S_RUN);
      PI_freeze    <= (state_n == S_RUN) && hold_req;
      at_target    <= (sp_n == target_n);
    end
  end

endmodule
